keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4-row x 3-column telephone-style matrix keypad and debounces presses.
- Produces the 4-bit key code consumed by the elevator Management login/admin FSM: digits 0000-1001, * = 1010, # = 1011, no key = 1111.
- Emits exactly one code cycle per physical press, so the downstream FSM advances once per keystroke.
- Runs on the divided clock clk_out, the same clock as Management.

Parameters:
- SCAN_DWELL, 4, clk_out cycles each row is driven while scanning; minimum 3, to cover the 2-FF synchronizer latency.
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release; minimum 1.

Ports:
- clk_out  input  1  divided system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- col_n  input  3  keypad column lines, active-low, externally pulled up, asynchronous to clk_out.
- row_n  output  4  keypad row drives, active-low, one-hot-low.
- key_code  output  4  key code for one cycle per press; 1111 at all other times.
- key_valid  output  1  high in the same cycle key_code is not 1111.
- key_busy  output  1  high from press detection until release is accepted.

Behaviour:
- Reset (RST low, asynchronous):
  - row_n=1110, key_code=1111, key_valid=0, key_busy=0.
  - State SCAN, row index 0, all counters 0, synchronizer flops = 111.
- Synchronizer: col_n passes through 2 flops giving col_s, so input-to-col_s latency is 2 cycles. All decisions use col_s only.
- Key map (row,col) -> code:
  - r0: 1,2,3 = 0001,0010,0011
  - r1: 4,5,6 = 0100,0101,0110
  - r2: 7,8,9 = 0111,1000,1001
  - r3: *,0,# = 1010,0000,1011
- State SCAN:
  - Drive row_n low on the current row only; the dwell counter counts 0..SCAN_DWELL-1.
  - On the last dwell cycle, sample col_s:
    - exactly one bit low -> latch row/col, clear the debounce counter, go to DEBOUNCE; the row stays driven.
    - all high, or 2+ bits low (ghost/multi-key) -> advance the row index, wrapping 3->0, and reset dwell.
  - key_busy=0.
- State DEBOUNCE:
  - Row held. Each cycle col_s equals the latched pattern -> counter+1. Any mismatch -> back to SCAN at the next row, no output.
  - When the counter reaches DEBOUNCE_CYCLES -> EMIT.
  - key_busy=1.
- State EMIT (exactly 1 cycle):
  - key_code=mapped code, key_valid=1, then go to WAIT_RELEASE.
  - key_code and key_valid are registered outputs, so they are asserted in the cycle after the DEBOUNCE->EMIT transition edge.
- State WAIT_RELEASE:
  - Row held, key_code=1111, key_busy=1.
  - col_s all high -> release counter+1; any low bit -> counter cleared.
  - Counter reaching DEBOUNCE_CYCLES -> SCAN at the next row, key_busy=0.
  - A held key never re-emits; pressing a second key while the first is held is ignored.
- Boundary conditions:
  - Bounce: any glitch shorter than DEBOUNCE_CYCLES consecutive stable cycles produces no code.
  - Reset mid-operation: an immediate return to the reset values; any pending emit is discarded.
  - Counter widths: $clog2(param+1). No counter exceeds its parameter.
- Worst-case press-to-code latency: 4*SCAN_DWELL + 2 + DEBOUNCE_CYCLES + 1 cycles.

Test Plan:
- Reset, then hold '5' (row1 low -> col_n=101) for 40 cycles, then release -> exactly one cycle key_code=0101 with key_valid=1; otherwise 1111. key_busy drops DEBOUNCE_CYCLES+2 cycles after release.
- Press '*', '0', '#' in turn, each held 30 cycles with 30-cycle gaps -> codes 1010, 0000, 1011 in order, one pulse each.
- Press '1' bouncing (2 cycles low, 1 high, repeated 5 times) then released -> no key_valid pulse.
- '7' and '9' held together (row2, col_n=010) -> no output; release '9' -> one pulse 0111.
- Hold '3' for 200 cycles -> single pulse 0011. Release and re-press -> second pulse 0011.
- Assert RST during DEBOUNCE of '8' -> outputs return immediately to row_n=1110, key_code=1111, key_busy=0. After RST deasserts with '8' still held -> one pulse 1000.

Source files
------------

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// Matrix keypad scanner for a 4-row x 3-column telephone keypad.
// Drives one row low at a time, synchronizes the column lines, debounces
// presses and releases, and emits a single-cycle key code per keystroke.
module keypad_scanner #(
  parameter int SCAN_DWELL      = 4,  // cycles each row is driven; >= 3
  parameter int DEBOUNCE_CYCLES = 4   // stable samples to accept press/release; >= 1
) (
  input  logic       clk_out,
  input  logic       RST,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_busy
);

  localparam int DW  = $clog2(SCAN_DWELL + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     NO_KEY     = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_e;

  state_e         state_q,    state_d;
  logic [1:0]     row_q,      row_d;
  logic [DW-1:0]  dwell_q,    dwell_d;
  logic [DBW-1:0] deb_q,      deb_d;
  logic [2:0]     col_lat_q,  col_lat_d;
  logic [2:0]     sync1_q,    sync1_d;
  logic [2:0]     col_s_q,    col_s_d;
  logic [3:0]     key_code_q, key_code_d;
  logic           key_valid_q, key_valid_d;

  logic           one_low;

  // Translate the held row and the single-low column pattern into a key code.
  function automatic logic [3:0] map_code(input logic [1:0] row, input logic [2:0] pat);
    logic [1:0] col;
    case (pat)
      3'b110:  col = 2'd0;
      3'b101:  col = 2'd1;
      default: col = 2'd2;
    endcase
    case ({row, col})
      4'b00_00: map_code = 4'b0001;  // 1
      4'b00_01: map_code = 4'b0010;  // 2
      4'b00_10: map_code = 4'b0011;  // 3
      4'b01_00: map_code = 4'b0100;  // 4
      4'b01_01: map_code = 4'b0101;  // 5
      4'b01_10: map_code = 4'b0110;  // 6
      4'b10_00: map_code = 4'b0111;  // 7
      4'b10_01: map_code = 4'b1000;  // 8
      4'b10_10: map_code = 4'b1001;  // 9
      4'b11_00: map_code = 4'b1010;  // *
      4'b11_01: map_code = 4'b0000;  // 0
      4'b11_10: map_code = 4'b1011;  // #
      default:  map_code = NO_KEY;
    endcase
  endfunction

  // Exactly one column low means a single unambiguous key on the driven row.
  assign one_low = (col_s_q == 3'b110) || (col_s_q == 3'b101) || (col_s_q == 3'b011);

  // Next-state logic: scan, debounce, one-cycle emit, then wait for a clean release.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves a latch behind.
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    col_lat_d   = col_lat_q;
    sync1_d     = col_n;
    col_s_d     = sync1_q;
    key_code_d  = NO_KEY;
    key_valid_d = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            col_lat_d = col_s_q;
            deb_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (col_s_q != col_lat_q) begin
          deb_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = ST_SCAN;
        end else if (deb_q == DEB_LAST) begin
          deb_d       = '0;
          state_d     = ST_EMIT;
          key_code_d  = map_code(row_q, col_lat_q);
          key_valid_d = 1'b1;
        end else begin
          deb_d = deb_q + DBW'(1);
        end
      end
      ST_EMIT: begin
        deb_d   = '0;
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (col_s_q != 3'b111) begin
          deb_d = '0;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = ST_SCAN;
        end else begin
          deb_d = deb_q + DBW'(1);
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // State and datapath registers; reset puts the scanner idle on row 0.
  always_ff @(posedge clk_out or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_SCAN;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      col_lat_q   <= 3'b111;
      // Synchronizer resets to "no column pulled low" so reset exit sees no key.
      sync1_q     <= 3'b111;
      col_s_q     <= 3'b111;
      key_code_q  <= NO_KEY;
      key_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      col_lat_q   <= col_lat_d;
      sync1_q     <= sync1_d;
      col_s_q     <= col_s_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_busy  = (state_q != ST_SCAN);

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Self-checking bench for keypad_scanner: a keypad matrix model drives the
// columns from the pressed-key set, a monitor collects emitted codes, and
// each scenario task compares against codes derived from the key map.
module tb_keypad_scanner;

  localparam int SCAN_DWELL      = 4;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LAT_MAX = 4 * SCAN_DWELL + 2 + DEBOUNCE_CYCLES + 1;
  localparam int LAT_MIN = 3 + DEBOUNCE_CYCLES;

  logic        clk_out = 1'b0;
  logic        RST     = 1'b1;
  logic [2:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_busy;

  logic [11:0] pressed = '0;   // bit k = key at row k/3, column k%3

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          viol         = 0;
  int          cycle        = 0;
  logic        prev_valid   = 1'b0;
  logic [3:0]  obs_q[$];
  int          obs_cycle[$];

  keypad_scanner #(
    .SCAN_DWELL      (SCAN_DWELL),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk_out   (clk_out),
    .RST       (RST),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_busy  (key_busy)
  );

  always #5 clk_out = ~clk_out;

  // Passive keypad: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && row_n[r] === 1'b0) col_n[c] = 1'b0;
  end

  // Monitor: record every emitted code and flag protocol violations each cycle.
  always @(negedge clk_out) begin
    cycle++;
    if (RST) begin
      if (key_valid === 1'b1) begin
        obs_q.push_back(key_code);
        obs_cycle.push_back(cycle);
      end
      if (key_valid !== (key_code !== 4'hF)) viol++;
      if ($countones(~row_n) != 1) viol++;
      if (key_valid === 1'b1 && key_busy !== 1'b1) viol++;
      if (key_valid === 1'b1 && prev_valid) viol++;
      prev_valid = (key_valid === 1'b1);
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Key code from the keypad legend: digits 1-9 in rows 0-2, then *, 0, #.
  function automatic logic [3:0] exp_code(input int k);
    int row = k / 3;
    int col = k % 3;
    if (row < 3) return 4'(row * 3 + col + 1);
    if (col == 0) return 4'd10;
    if (col == 1) return 4'd0;
    return 4'd11;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_out);
      #1;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cycle.delete();
    viol = 0;
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    tick(3);
    tests_run++;
    if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL reset_row_n: got %b expected 1110", row_n); end
    tests_run++;
    if (key_code !== 4'hF) begin tests_failed++; $display("FAIL reset_key_code: got %b expected 1111", key_code); end
    tests_run++;
    if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    tests_run++;
    if (key_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_key_busy: got %b expected 0", key_busy); end
    RST = 1'b1;
    clear_obs();
    tick(30);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL idle_no_code: got %0d codes expected 0", obs_q.size()); end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL idle_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_single_key();
    int drop;
    clear_obs();
    pressed[4] = 1'b1;   // '5'
    tick(40);
    pressed[4] = 1'b0;
    drop = 50;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (key_busy === 1'b0) begin drop = i; break; end
    end
    tick(10);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", obs_q.size()); end
    tests_run++;
    if ((obs_q.size() > 0 ? obs_q[0] : 4'hx) !== 4'b0101)
      begin tests_failed++; $display("FAIL single_code: got %b expected 0101", obs_q.size() > 0 ? obs_q[0] : 4'hx); end
    tests_run++;
    if (drop != DEBOUNCE_CYCLES + 2)
      begin tests_failed++; $display("FAIL busy_drop: got %0d cycles expected %0d", drop, DEBOUNCE_CYCLES + 2); end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL single_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_bottom_row();
    logic [3:0] exp [3] = '{4'b1010, 4'b0000, 4'b1011};
    clear_obs();
    for (int k = 9; k <= 11; k++) begin
      pressed[k] = 1'b1;
      tick(30);
      pressed[k] = 1'b0;
      tick(30);
    end
    tests_run++;
    if (obs_q.size() != 3) begin tests_failed++; $display("FAIL bottom_count: got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ((obs_q.size() > i ? obs_q[i] : 4'hx) !== exp[i])
        begin tests_failed++; $display("FAIL bottom_code%0d: got %b expected %b", i, obs_q.size() > i ? obs_q[i] : 4'hx, exp[i]); end
    end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL bottom_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_bounce();
    clear_obs();
    repeat (5) begin
      pressed[0] = 1'b1;   // '1'
      tick(2);
      pressed[0] = 1'b0;
      tick(1);
    end
    tick(30);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL bounce_no_code: got %0d codes expected 0", obs_q.size()); end
    tests_run++;
    if (key_busy !== 1'b0) begin tests_failed++; $display("FAIL bounce_busy: got %b expected 0", key_busy); end
  endtask

  task automatic test_ghost();
    clear_obs();
    pressed[6] = 1'b1;   // '7'
    pressed[8] = 1'b1;   // '9'
    tick(40);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL ghost_no_code: got %0d codes expected 0", obs_q.size()); end
    pressed[8] = 1'b0;
    tick(40);
    pressed[6] = 1'b0;
    tick(20);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL ghost_count: got %0d expected 1", obs_q.size()); end
    tests_run++;
    if ((obs_q.size() > 0 ? obs_q[0] : 4'hx) !== 4'b0111)
      begin tests_failed++; $display("FAIL ghost_code: got %b expected 0111", obs_q.size() > 0 ? obs_q[0] : 4'hx); end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL ghost_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_long_hold();
    clear_obs();
    pressed[2] = 1'b1;   // '3'
    tick(200);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL hold_count: got %0d expected 1", obs_q.size()); end
    pressed[2] = 1'b0;
    tick(30);
    pressed[2] = 1'b1;
    tick(40);
    pressed[2] = 1'b0;
    tick(20);
    tests_run++;
    if (obs_q.size() != 2) begin tests_failed++; $display("FAIL repress_count: got %0d expected 2", obs_q.size()); end
    tests_run++;
    if ((obs_q.size() > 1 ? obs_q[1] : 4'hx) !== 4'b0011)
      begin tests_failed++; $display("FAIL repress_code: got %b expected 0011", obs_q.size() > 1 ? obs_q[1] : 4'hx); end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL hold_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_reset_mid_debounce();
    bit seen = 1'b0;
    clear_obs();
    pressed[7] = 1'b1;   // '8'
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (key_busy === 1'b1) begin seen = 1'b1; break; end
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL debounce_entry: got timeout expected key_busy within 100 cycles"); end
    RST = 1'b0;
    #1;
    tests_run++;
    if (row_n !== 4'b1110) begin tests_failed++; $display("FAIL midrst_row_n: got %b expected 1110", row_n); end
    tests_run++;
    if (key_code !== 4'hF) begin tests_failed++; $display("FAIL midrst_key_code: got %b expected 1111", key_code); end
    tests_run++;
    if (key_busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_key_busy: got %b expected 0", key_busy); end
    tick(4);
    tests_run++;
    if (obs_q.size() != 0) begin tests_failed++; $display("FAIL midrst_discard: got %0d codes expected 0", obs_q.size()); end
    RST = 1'b1;
    tick(40);
    pressed[7] = 1'b0;
    tick(20);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL after_rst_count: got %0d expected 1", obs_q.size()); end
    tests_run++;
    if ((obs_q.size() > 0 ? obs_q[0] : 4'hx) !== 4'b1000)
      begin tests_failed++; $display("FAIL after_rst_code: got %b expected 1000", obs_q.size() > 0 ? obs_q[0] : 4'hx); end
  endtask

  task automatic test_random();
    int k, hold, gap, runs, press_cycle, lat;
    viol = 0;
    for (int it = 0; it < 16; it++) begin
      obs_q.delete();
      obs_cycle.delete();
      k    = int'($urandom_range(0, 11));
      hold = int'($urandom_range(30, 60));
      gap  = int'($urandom_range(20, 40));
      runs = int'($urandom_range(0, 3));
      for (int b = 0; b < runs; b++) begin
        pressed[k] = 1'b1;
        tick(int'($urandom_range(1, DEBOUNCE_CYCLES - 1)));
        pressed[k] = 1'b0;
        tick(int'($urandom_range(1, 3)));
      end
      tick(10);
      tests_run++;
      if (obs_q.size() != 0) begin tests_failed++; $display("FAIL rand%0d_glitch: got %0d codes expected 0", it, obs_q.size()); end
      pressed[k] = 1'b1;
      press_cycle = cycle;
      tick(hold);
      pressed[k] = 1'b0;
      tick(gap);
      tests_run++;
      if (obs_q.size() != 1) begin tests_failed++; $display("FAIL rand%0d_count: got %0d expected 1", it, obs_q.size()); end
      tests_run++;
      if ((obs_q.size() > 0 ? obs_q[0] : 4'hx) !== exp_code(k))
        begin tests_failed++; $display("FAIL rand%0d_code: got %b expected %b", it, obs_q.size() > 0 ? obs_q[0] : 4'hx, exp_code(k)); end
      lat = (obs_cycle.size() > 0) ? obs_cycle[0] - press_cycle : -1;
      tests_run++;
      if (lat < LAT_MIN || lat > LAT_MAX)
        begin tests_failed++; $display("FAIL rand%0d_latency: got %0d expected %0d..%0d", it, lat, LAT_MIN, LAT_MAX); end
    end
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL rand_protocol: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bottom_row();
    test_bounce();
    test_ghost();
    test_long_hold();
    test_reset_mid_debounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
